// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//   Round-robin arbiter and sequencer in front of a 2:1 data mux. Two
//   producers share one downstream consumer. Grants are registered, the mux
//   select is registered, and each grant is limited to MAX_BURST transfers
//   while the other side is waiting, so neither requester can starve.
//
// Parameters
//   WIDTH      data width of each requester and of the output
//   MAX_BURST  transfers allowed per grant while the other side waits (>= 1)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   req0, d0   requester 0 valid flag and data
//   req1, d1   requester 1 valid flag and data
//   gnt0       requester 0 owns the output (registered)
//   gnt1       requester 1 owns the output (registered)
//   sel        mux select, 0 -> d0, 1 -> d1 (registered)
//   out_valid  output data valid (combinational)
//   out_data   selected data (combinational)
//   out_ready  consumer accepts data

module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             sel_q, sel_d;

  logic             xfer;
  logic             burst_done;
  logic [CNT_W-1:0] burst_inc;

  // Output path is purely combinational from the registered grant/select
  // and the live request/data inputs.
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign sel       = sel_q;
  assign out_valid = (gnt0_q & req0) | (gnt1_q & req1);
  assign out_data  = sel_q ? d1 : d0;

  assign xfer       = out_valid & out_ready;
  assign burst_inc  = burst_cnt_q + CNT_W'(1);
  // The transfer that brings the count to the limit ends the burst; the
  // counter therefore never holds a value above MAX_BURST.
  assign burst_done = xfer & (burst_inc == BURST_LIMIT);

  // Next-state logic. Every move into a grant state clears the burst count
  // and records the new owner in last, which breaks the next tie.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          state_d     = GNT0;
          last_d      = 1'b0;
          burst_cnt_d = '0;
        end else if (req1) begin
          state_d     = GNT1;
          last_d      = 1'b1;
          burst_cnt_d = '0;
        end
      end

      GNT0: begin
        if (!req0) begin
          burst_cnt_d = '0;
          if (req1) begin
            state_d = GNT1;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (burst_done) begin
          // Hand over if the other side waits, otherwise start a fresh burst.
          burst_cnt_d = '0;
          if (req1) begin
            state_d = GNT1;
            last_d  = 1'b1;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_inc;
        end
      end

      GNT1: begin
        if (!req1) begin
          burst_cnt_d = '0;
          if (req0) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (burst_done) begin
          burst_cnt_d = '0;
          if (req0) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_inc;
        end
      end

      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase

    // Grants and select are registered copies decoded from the next state,
    // so they change together with the state register.
    gnt0_d = (state_d == GNT0);
    gnt1_d = (state_d == GNT1);
    sel_d  = (state_d == GNT1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      sel_q       <= sel_d;
    end
  end

endmodule
